// File: rtl/sram_lp_pkg.sv
// Shared types and helpers for the low-power single-port SRAM wrapper.
//   lp_state_t : power state encoding exported on lp_state
//   LP_STATE_W : width of lp_state
//   clog2      : ceiling log2, used to size address and counter fields
package sram_lp_pkg;

  localparam int LP_STATE_W = 2;

  typedef enum logic [LP_STATE_W-1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } lp_state_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_sp_core.sv
// Behavioural byte-masked single-port memory array. This model is a drop-in
// for the SRAM macro: same pins and the same one-cycle registered read.
//   CLK   : clock
//   ME    : memory enable (one access per asserted cycle)
//   WEM   : per-byte write mask, all zero selects a read
//   ADR   : word address
//   D     : write data
//   PD    : power-down, blocks any access while asserted
//   Q_mem : registered read data, changes only on a read
module sram_sp_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic                CLK,
  input  logic                ME,
  input  logic [DATA_W/8-1:0] WEM,
  input  logic [ADDR_W-1:0]   ADR,
  input  logic [DATA_W-1:0]   D,
  input  logic                PD,
  output logic [DATA_W-1:0]   Q_mem
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (ME && !PD) begin
      if (WEM == '0) begin
        Q_mem <= mem[ADR];
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (WEM[i]) begin
            mem[ADR][i*8 +: 8] <= D[i*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/sram_sp_lp_wrap.sv
// Single-port SRAM wrapper with byte enables, read-valid pulse, req/gnt
// handshake and an idle power-down controller (ACTIVE -> SLEEP -> WAKE).
//   CLK, reset : clock and synchronous active-high reset
//   scan_mode  : forces ACTIVE, blocks sleep, grants every request
//   req / gnt  : access handshake, access happens when both are high
//   WE, ADR, D : byte write enables (all zero = read), address, write data
//   Q, q_valid : read data (held between reads) and its one-cycle pulse
//   lp_state   : 0 ACTIVE, 1 SLEEP, 2 WAKE
//   dft_obs    : {address/control XOR, data XOR} observation flops
module sram_sp_lp_wrap
  import sram_lp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2048,
  parameter int ADDR_W      = 11,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  scan_mode,
  input  logic                  req,
  output logic                  gnt,
  input  logic [DATA_W/8-1:0]   WE,
  input  logic [ADDR_W-1:0]     ADR,
  input  logic [DATA_W-1:0]     D,
  output logic [DATA_W-1:0]     Q,
  output logic                  q_valid,
  output logic [LP_STATE_W-1:0] lp_state,
  output logic [1:0]            dft_obs
);

  localparam int IDLE_W = (clog2(IDLE_CYCLES + 1) < 1) ? 1 : clog2(IDLE_CYCLES + 1);
  localparam int WAKE_W = (clog2(WAKE_CYCLES + 1) < 1) ? 1 : clog2(WAKE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  lp_state_t         state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              me, pd;
  logic              rd_p0, vld_p1;
  logic [DATA_W-1:0] q_mem, q_hold;
  logic              addr_xor_ff, data_xor_ff;

  // Idle counter stops at all-ones instead of wrapping back to zero.
  function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + IDLE_W'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ACTIVE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (scan_mode) begin
      state_nxt = ACTIVE;
    end else begin
      case (state)
        // A request on the threshold cycle keeps us ACTIVE.
        ACTIVE:  if (IDLE_CYCLES != 0 && !req && idle_cnt == IDLE_LAST) state_nxt = SLEEP;
        SLEEP:   if (req) state_nxt = WAKE;
        WAKE:    if (wake_cnt == WAKE_LAST) state_nxt = ACTIVE;
        default: state_nxt = ACTIVE;
      endcase
    end
  end

  always_comb begin
    gnt      = req & ((state == ACTIVE) | scan_mode);
    me       = gnt;
    pd       = (state == SLEEP) & ~scan_mode;
    lp_state = state;
  end

  always_ff @(posedge CLK) begin
    if (reset || scan_mode) begin
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      idle_cnt <= (state == ACTIVE && !req) ? sat_inc(idle_cnt) : '0;
      wake_cnt <= (state == WAKE) ? wake_cnt + WAKE_W'(1) : '0;
    end
  end

  sram_sp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .CLK   (CLK),
    .ME    (me),
    .WEM   (WE),
    .ADR   (ADR),
    .D     (D),
    .PD    (pd),
    .Q_mem (q_mem)
  );

  // ---- p0: granted access presented to the array ----
  assign rd_p0 = me & ~(|WE);

  // ---- p1: array read data valid ----
  // Q shows fresh array data during the valid pulse and the held copy
  // otherwise, so the hold register never adds a cycle of latency and
  // reset can force Q to zero without touching the array.
  always_ff @(posedge CLK) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      q_hold <= '0;
    end else begin
      vld_p1 <= rd_p0;
      if (vld_p1) q_hold <= q_mem;
    end
  end

  assign Q       = vld_p1 ? q_mem : q_hold;
  assign q_valid = vld_p1;

  always_ff @(posedge CLK) begin
    if (reset) begin
      addr_xor_ff <= 1'b0;
      data_xor_ff <= 1'b0;
    end else begin
      addr_xor_ff <= (^ADR) ^ me ^ (^WE);
      data_xor_ff <= ^D;
    end
  end

  assign dft_obs = {addr_xor_ff, data_xor_ff};

endmodule

// File: tb/tb_sram_sp_lp_wrap.sv
module tb_sram_sp_lp_wrap;

  logic        CLK = 1'b0;
  logic        reset, scan_mode, req, gnt, q_valid;
  logic [3:0]  WE;
  logic [10:0] ADR;
  logic [31:0] D, Q;
  logic [1:0]  lp_state, dft_obs;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [int];
  logic [31:0] sb_q [$];

  sram_sp_lp_wrap #(
    .DATA_W(32), .DEPTH(2048), .ADDR_W(11), .IDLE_CYCLES(8), .WAKE_CYCLES(3)
  ) dut (
    .CLK(CLK), .reset(reset), .scan_mode(scan_mode), .req(req), .gnt(gnt),
    .WE(WE), .ADR(ADR), .D(D), .Q(Q), .q_valid(q_valid),
    .lp_state(lp_state), .dft_obs(dft_obs)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_wr(input logic [10:0] a, input logic [3:0] we, input logic [31:0] d);
    logic [31:0] cur;
    cur = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
    for (int i = 0; i < 4; i++) if (we[i]) cur[i*8 +: 8] = d[i*8 +: 8];
    model[int'(a)] = cur;
  endfunction

  task automatic next();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 1'b0; WE = '0; scan_mode = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
  endtask

  // Holds req until granted; the expected read data is queued at the grant.
  task automatic access(input logic [3:0] we, input logic [10:0] adr, input logic [31:0] d,
                        output int stalls);
    stalls = 0;
    req = 1'b1; WE = we; ADR = adr; D = d;
    forever begin
      @(negedge CLK);
      if (gnt) break;
      stalls++;
      if (stalls > 30) break;
      next();
    end
    if (gnt) begin
      if (we == 4'h0) sb_q.push_back(model[int'(adr)]);
      else model_wr(adr, we, d);
    end else begin
      chk("gnt_timeout", {31'b0, gnt}, 32'h1);
    end
    next();
    req = 1'b0; WE = '0;
  endtask

  // Counts ACTIVE/WAKE cycles until SLEEP is seen; ends on a SLEEP negedge.
  task automatic wait_sleep(output int n);
    n = 0;
    forever begin
      @(negedge CLK);
      if (lp_state == 2'd1) break;
      n++;
      if (n > 40) begin
        chk("sleep_timeout", {30'b0, lp_state}, 32'h1);
        break;
      end
      next();
    end
  endtask

  // Monitor: q_valid must pulse exactly one cycle after each granted read
  // (unless reset intervened), Q must match the queued data and hold it.
  initial begin
    logic        armed, prev_rst, prev_rd, exp_qv;
    logic [31:0] exp_q;
    armed = 1'b0; prev_rst = 1'b0; prev_rd = 1'b0; exp_q = '0;
    forever begin
      @(negedge CLK);
      if (armed) begin
        exp_qv = 1'b0;
        if (prev_rst) begin
          exp_q = '0;
        end else if (prev_rd) begin
          exp_qv = 1'b1;
          if (sb_q.size() == 0) chk("sb_underflow", 32'h0, 32'h1);
          else exp_q = sb_q.pop_front();
        end
        chk("q_valid", {31'b0, q_valid}, {31'b0, exp_qv});
        chk("Q", Q, exp_q);
      end
      prev_rst = reset;
      prev_rd  = req & gnt & (WE == 4'h0);
      if (reset) armed = 1'b1;
    end
  end

  initial begin
    int st, n;
    logic [10:0] pool [16];
    reset = 1'b1; scan_mode = 1'b0; req = 1'b0; WE = '0; ADR = '0; D = '0;

    // Reset state
    next();
    @(negedge CLK);
    chk("rst_lp_state", {30'b0, lp_state}, 32'h0);
    chk("rst_gnt", {31'b0, gnt}, 32'h0);
    chk("rst_dft", {30'b0, dft_obs}, 32'h0);
    next();
    reset = 1'b0;

    // Idle entry: SLEEP on the 9th idle cycle
    wait_sleep(n);
    chk("idle_entry_cycles", n, 8);

    // Request on the 8th idle cycle wins over the threshold
    do_reset();
    repeat (7) next();
    access(4'hF, 11'h7FF, 32'hAABBCCDD, st);
    chk("thresh_req_stall", st, 0);
    @(negedge CLK);
    chk("thresh_stay_active", {30'b0, lp_state}, 32'h0);
    next();

    // Byte write then read back
    access(4'h2, 11'h7FF, 32'h00001100, st);
    access(4'h0, 11'h7FF, 32'h0, st);
    chk("read_stall_active", st, 0);
    repeat (2) next();

    // Wake stall: WAKE_CYCLES+1 cycles without grant
    wait_sleep(n);
    next();
    access(4'h0, 11'h7FF, 32'h0, st);
    chk("wake_stall", st, 4);
    repeat (2) next();

    // Reset in WAKE with wake_cnt=1
    wait_sleep(n);
    next();
    req = 1'b1; WE = 4'h0; ADR = 11'h7FF; D = 32'h0000_0001;
    @(negedge CLK);
    chk("sleep_no_gnt", {31'b0, gnt}, 32'h0);
    next();
    @(negedge CLK);
    chk("wake_lp_state", {30'b0, lp_state}, 32'h2);
    chk("wake_no_gnt", {31'b0, gnt}, 32'h0);
    next();
    reset = 1'b1; req = 1'b0;
    @(negedge CLK);
    chk("wake1_lp_state", {30'b0, lp_state}, 32'h2);
    next();
    reset = 1'b0;
    @(negedge CLK);
    chk("wake_rst_lp_state", {30'b0, lp_state}, 32'h0);
    chk("wake_rst_dft", {30'b0, dft_obs}, 32'h0);
    next();

    // scan_mode while asleep: immediate grant, back to ACTIVE, never sleeps
    wait_sleep(n);
    next();
    scan_mode = 1'b1;
    access(4'h0, 11'h7FF, 32'h0, st);
    chk("scan_gnt_in_sleep", st, 0);
    @(negedge CLK);
    chk("scan_lp_active", {30'b0, lp_state}, 32'h0);
    next();
    n = 0;
    repeat (100) begin
      @(negedge CLK);
      if (lp_state != 2'd0) n++;
      next();
    end
    chk("scan_no_sleep", n, 0);
    scan_mode = 1'b0;
    wait_sleep(n);
    chk("post_scan_idle_cycles", n, 8);
    next();

    // DFT observation flops
    access(4'hF, 11'h001, 32'h1234_5678, st);
    access(4'hF, 11'h003, 32'h0F0F_0F0F, st);
    access(4'h0, 11'h001, 32'h0000_0003, st);
    @(negedge CLK);
    chk("dft_obs_00", {30'b0, dft_obs}, 32'h0);
    next();
    access(4'h0, 11'h003, 32'h0000_0001, st);
    @(negedge CLK);
    chk("dft_obs_11", {30'b0, dft_obs}, 32'h3);
    next();

    // Randomized traffic with idle gaps long enough to sleep and wake
    for (int i = 0; i < 16; i++) begin
      pool[i] = 11'($urandom_range(0, 2047));
      access(4'hF, pool[i], $urandom, st);
    end
    for (int i = 0; i < 150; i++) begin
      logic [3:0] we;
      repeat ($urandom_range(0, 12)) next();
      we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(we, pool[$urandom_range(0, 15)], $urandom, st);
    end

    repeat (3) next();
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_sp_lp_wrap.md
Name: sram_sp_lp_wrap

Overview:
- Parametrised single-port SRAM wrapper with byte write enables, registered read-valid and an automatic idle power-down controller.
- Sits between a bus slave (AHB/APB memory interface) and the SRAM macro, in the same slot as the fixed-size SRAM wrappers.
- Adds a req/gnt handshake, so the requester stalls while the macro wakes from sleep.
- Keeps the DFT address/data XOR observation flops.

Parameters:
- DATA_W, 32: data width in bits; must be a multiple of 8.
- DEPTH, 2048: number of words.
- ADDR_W, 11: address width; must satisfy ADDR_W = clog2(DEPTH).
- IDLE_CYCLES, 16: number of consecutive idle ACTIVE cycles before entering SLEEP; 0 disables sleep.
- WAKE_CYCLES, 2: number of cycles spent in WAKE before ACTIVE; must be 1 or more.

Ports:
- CLK, input, 1: the single clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- scan_mode, input, 1: forces ACTIVE, disables sleep, and drives macro AWT.
- req, input, 1: access request.
- gnt, output, 1: access accepted this cycle.
- WE, input, DATA_W/8: byte write enables; all zero means a read.
- ADR, input, ADDR_W: word address.
- D, input, DATA_W: write data.
- Q, output, DATA_W: read data.
- q_valid, output, 1: one-cycle pulse; Q holds new read data.
- lp_state, output, 2: 0 = ACTIVE, 1 = SLEEP, 2 = WAKE.
- dft_obs, output, 2: {addr_xor_ff, data_xor_ff}.

Behaviour:
- Reset values: state ACTIVE; idle_cnt 0; wake_cnt 0; Q 0; q_valid 0; dft_obs 0; gnt follows its combinational equation. Memory contents are not reset.
- gnt = req & (state == ACTIVE), combinational. An access happens exactly when req & gnt.
- Access: macro ME = req & gnt; per-byte write mask = WE; macro PD = (state == SLEEP).
- Write: all bytes with WE[i]=1 are written at the edge; other bytes are unchanged. No q_valid.
- Read (WE all zero): Q updates and q_valid=1 on the edge after the grant edge, i.e. 1-cycle latency.
- Q holds its last read value until the next read. Writes and sleep do not change Q.
- Read-during-write does not occur (single port).
- FSM ACTIVE:
  - req resets idle_cnt to 0.
  - Without req, idle_cnt increments.
  - When idle_cnt == IDLE_CYCLES-1 and there is no req, go to SLEEP next cycle.
  - req in the same cycle as the threshold wins: grant, stay ACTIVE, idle_cnt reset.
- FSM SLEEP: contents retained. req moves to WAKE next cycle with wake_cnt=0; gnt=0.
- FSM WAKE: gnt=0; wake_cnt increments; at wake_cnt == WAKE_CYCLES-1 go to ACTIVE.
  - A held req is granted on the first ACTIVE cycle.
  - Total stall from req in SLEEP to gnt = WAKE_CYCLES+1 cycles.
- Requester rules:
  - Must hold req, ADR, WE and D stable until gnt.
  - Dropping req during WAKE is legal; the FSM still completes WAKE and then idles back toward SLEEP.
- Counter width: idle_cnt = clog2(IDLE_CYCLES+1) bits; saturates, never wraps.
- IDLE_CYCLES=0: never leave ACTIVE.
- scan_mode=1: next state ACTIVE from any state; counters held at 0; gnt = req.
- Reset asserted mid-WAKE or mid-SLEEP: ACTIVE next cycle, with no q_valid. A read granted the cycle before reset produces no q_valid.
- dft_obs:
  - addr_xor = XOR of ADR, ME and WE.
  - data_xor = XOR of D.
  - Both registered every cycle regardless of state.

Decomposition:
- Package sram_lp_pkg:
  - lp_state_t enum: ACTIVE=2'd0, SLEEP=2'd1, WAKE=2'd2.
  - LP_STATE_W=2.
  - clog2 helper function.
- Sub-module sram_sp_core:
  - Parametrised behavioural byte-masked single-port array.
  - Inputs ME, WEM, ADR, D, PD; registered Q_mem.
  - Swapped for the macro instance under FV_KIT_RTL_MEMORY_MODELS not defined.
- The wrapper owns the FSM, counters, q_valid, the Q hold register and the DFT flops.

Test Plan (defaults DATA_W=32, DEPTH=2048, IDLE_CYCLES=8, WAKE_CYCLES=3):
- Byte write: write ADR=0x7FF D=0xAABBCCDD WE=4'hF, then WE=4'h2 D=0x00001100, then read -> Q=0xAABB11DD, q_valid one cycle after gnt, exactly 1 cycle wide.
- Idle entry: no req for 8 cycles after reset deasserts -> lp_state=1 on the 9th cycle. Re-run with req on the 8th idle cycle -> gnt=1, lp_state stays 0.
- Wake stall: req held from SLEEP with read ADR=0x7FF -> gnt=0 for 4 cycles, gnt=1 on the 5th, Q=0xAABB11DD one cycle later, contents retained.
- scan_mode=1 asserted while in SLEEP -> lp_state=0 next cycle, gnt=req. 100 idle cycles give no SLEEP.
- Reset asserted in WAKE (wake_cnt=1) -> lp_state=0, Q=0, q_valid=0, dft_obs=0 next cycle.
- DFT: ADR=0x001, WE=0, D=0x00000003 with ME=1 -> dft_obs=2'b00. ADR=0x003, D=0x1, ME=1 -> dft_obs=2'b11.
